// File: rtl/surf_scaler_bank.sv
// surf_scaler_bank: per-channel rising-edge scalers counted over a fixed
// window, snapshotted into holding registers with a valid/ack/lost handshake.
module surf_scaler_bank #(
  parameter int NSCAL  = 32,
  parameter int CNT_W  = 16,
  parameter int PERIOD = 33333333
) (
  input  logic             mclk_i,
  input  logic             rst_n_i,
  input  logic [NSCAL-1:0] scal_i,
  input  logic [4:0]       rd_addr_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             valid_o,
  input  logic             ack_i,
  output logic             lost_o,
  output logic             period_done_o
);

  localparam int WIN_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [WIN_W-1:0] LAST = WIN_W'(PERIOD - 1);

  logic [WIN_W-1:0] r_win;
  logic [NSCAL-1:0] r_prev;
  logic [CNT_W-1:0] r_live [NSCAL];
  logic [CNT_W-1:0] r_hold [NSCAL];
  logic [CNT_W-1:0] r_rd;
  logic             r_valid;
  logic             r_lost;
  logic             r_pd;

  logic [CNT_W-1:0] w_next [NSCAL];
  logic [CNT_W-1:0] w_rd   [32];
  logic [NSCAL-1:0] w_edge;
  logic             w_term;
  logic             w_acc;

  assign w_edge = scal_i & ~r_prev;
  assign w_term = (r_win == LAST);
  assign w_acc  = ack_i & r_valid;

  // live count plus this cycle's edge, pinned at all-ones
  for (genvar g = 0; g < NSCAL; g++) begin : g_sat
    assign w_next[g] = (&r_live[g]) ? r_live[g]
                     : r_live[g] + CNT_W'(w_edge[g]);
  end

  // unused addresses read back as zero
  for (genvar g = 0; g < 32; g++) begin : g_rd
    if (g < NSCAL) begin : g_on
      assign w_rd[g] = r_hold[g];
    end else begin : g_off
      assign w_rd[g] = '0;
    end
  end

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_win <= '0;
    end else if (w_term) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + WIN_W'(1);
    end
  end

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_prev <= '0;
      for (int i = 0; i < NSCAL; i++) begin
        r_live[i] <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      r_prev <= scal_i;
      for (int i = 0; i < NSCAL; i++) begin
        if (w_term) begin
          r_hold[i] <= w_next[i];
          r_live[i] <= '0;
        end else begin
          r_live[i] <= w_next[i];
        end
      end
    end
  end

  // a new snapshot wins over a coincident ack
  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pd    <= 1'b0;
      r_valid <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_pd <= w_term;
      if (w_term) begin
        r_valid <= 1'b1;
      end else if (w_acc) begin
        r_valid <= 1'b0;
      end
      if (w_term & r_valid & ~ack_i) begin
        r_lost <= 1'b1;
      end else if (w_acc) begin
        r_lost <= 1'b0;
      end
    end
  end

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd[rd_addr_i];
    end
  end

  assign rd_data_o     = r_rd;
  assign valid_o       = r_valid;
  assign lost_o        = r_lost;
  assign period_done_o = r_pd;

endmodule

// File: tb/tb_surf_scaler_bank.sv
// tb_surf_scaler_bank: random pulses vs. an integer window model,
// snapshots queued and swept back through the read port.
module tb_surf_scaler_bank;

  localparam int NSCAL  = 22;
  localparam int CNT_W  = 4;
  localparam int PERIOD = 40;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [NSCAL-1:0] scal;
  logic [4:0]       rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             valid;
  logic             ack;
  logic             lost;
  logic             pd;

  surf_scaler_bank #(
    .NSCAL (NSCAL),
    .CNT_W (CNT_W),
    .PERIOD(PERIOD)
  ) dut (
    .mclk_i       (clk),
    .rst_n_i      (rst_n),
    .scal_i       (scal),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .valid_o      (valid),
    .ack_i        (ack),
    .lost_o       (lost),
    .period_done_o(pd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: integer edge counts per window position
  int               cnt [NSCAL];
  logic [NSCAL-1:0] prv = '0;
  int               cyc = 0;
  bit               ev  = 0;
  bit               el  = 0;
  bit               epd = 0;
  int               last_snap [32];
  int               exp_q [$];

  initial begin
    for (int a = 0; a < 32; a++) last_snap[a] = 0;
    for (int n = 0; n < NSCAL; n++) cnt[n] = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; prv = '0; ev = 0; el = 0; epd = 0;
      for (int n = 0; n < NSCAL; n++) cnt[n] = 0;
      for (int a = 0; a < 32; a++) last_snap[a] = 0;
      exp_q.delete();
    end else begin
      bit term, acc, nv, nl;
      for (int n = 0; n < NSCAL; n++)
        if (scal[n] && !prv[n]) cnt[n]++;
      prv  = scal;
      term = (cyc == PERIOD - 1);
      acc  = ack && ev;
      nv = ev; nl = el;
      if (acc) begin nv = 0; nl = 0; end
      if (term) nv = 1;
      if (term && ev && !ack) nl = 1;
      ev = nv; el = nl; epd = term;
      if (term) begin
        for (int a = 0; a < 32; a++) begin
          if (a < NSCAL) exp_q.push_back(cnt[a] > MAXC ? MAXC : cnt[a]);
          else           exp_q.push_back(0);
        end
        for (int n = 0; n < NSCAL; n++) cnt[n] = 0;
        cyc = 0;
      end else begin
        cyc++;
      end
    end
  end

  // flag checker every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", int'(valid), 0);
      chk("rst_lost",  int'(lost),  0);
      chk("rst_pd",    int'(pd),    0);
      chk("rst_rd",    int'(rd_data), 0);
    end else begin
      chk("valid", int'(valid), int'(ev));
      chk("lost",  int'(lost),  int'(el));
      chk("pdone", int'(pd),    int'(epd));
    end
  end

  // snapshot monitor: pops on period_done and sweeps the read port
  initial begin
    int cur [32];
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n && pd) begin
        chk("rd_old_snap", int'(rd_data), last_snap[rd_addr]);
        if (exp_q.size() < 32) begin
          chk("snap_queue", exp_q.size(), 32);
        end else begin
          for (int a = 0; a < 32; a++) cur[a] = exp_q.pop_front();
          for (int a = 0; a < 32; a++) last_snap[a] = cur[a];
          for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            @(negedge clk);
            chk($sformatf("rd[%0d]", a), int'(rd_data), cur[a]);
          end
          rd_addr = '0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic align(input int p);
    tick(); scal = '0; ack = 1'b0;
    while (cyc != p) begin
      tick(); scal = '0; ack = 1'b0;
    end
  endtask

  function automatic logic [NSCAL-1:0] rnd_scal();
    return NSCAL'($urandom & $urandom);
  endfunction

  initial begin
    int  n;
    bit  tog;
    bit  pulsed;
    rst_n = 1'b0; scal = '0; ack = 1'b0;
    repeat (3) tick();
    chk("init_rd",    int'(rd_data), 0);
    chk("init_valid", int'(valid), 0);
    #1 rst_n = 1'b1;

    // random pulses and sparse acks
    repeat (4 * PERIOD) begin
      tick(); scal = rnd_scal(); ack = ($urandom_range(0, 7) == 0);
    end

    // saturation on ch0, held level on ch1
    tog = 0;
    repeat (2 * PERIOD) begin
      tick();
      scal = rnd_scal();
      scal[0] = tog; tog = ~tog;
      scal[1] = 1'b1;
      ack = ($urandom_range(0, 3) == 0);
    end

    // single edge on the terminal cycle only
    pulsed = 0;
    repeat (3 * PERIOD) begin
      tick();
      scal = '0;
      if (cyc == PERIOD - 1 && !pulsed) begin
        scal[7] = 1'b1; pulsed = 1;
      end
      ack = ($urandom_range(0, 3) == 0);
    end

    // handshake: lost after two unacked snapshots, then acks
    align(0);
    repeat (2 * PERIOD + 5) begin
      tick(); scal = rnd_scal(); ack = 1'b0;
    end
    chk("lost_set",  int'(lost),  1);
    chk("valid_set", int'(valid), 1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("ack_valid", int'(valid), 0);
    chk("ack_lost",  int'(lost),  0);
    align(PERIOD - 1);
    tick();
    align(PERIOD - 1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("ackterm_valid", int'(valid), 1);
    chk("ackterm_lost",  int'(lost),  0);

    // reset mid-window with pending counts
    align(30);
    scal[2] = 1'b1; tick(); scal = '0; tick();
    scal[2] = 1'b1; tick(); scal = '0;
    align(36);
    scal[3] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rd",    int'(rd_data), 0);
    chk("async_valid", int'(valid), 0);
    chk("async_lost",  int'(lost), 0);
    chk("async_pd",    int'(pd), 0);
    repeat (3) tick();
    #1 rst_n = 1'b1;
    n = 0;
    while (n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
      if (pd) break;
    end
    chk("rst_first_snap_latency", n, PERIOD);

    // more random traffic with acks
    repeat (2 * PERIOD + 36) begin
      tick(); scal = rnd_scal(); ack = ($urandom_range(0, 4) == 0);
    end
    tick(); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
